// File: rtl/bist_engine_param.sv
// Parametrised LFSR/MISR BIST engine for an external, optionally pipelined CUT.
// Sequences seed load, pattern run, pipeline drain and golden compare/learn.
module bist_engine_param #(
    parameter int PAT_WIDTH    = 8,
    parameter int RESP_WIDTH   = 8,
    parameter int NUM_PATTERNS = 15,
    parameter int CUT_LATENCY  = 0,
    parameter logic [PAT_WIDTH-1:0]  LFSR_TAPS = 8'hB8,
    parameter logic [PAT_WIDTH-1:0]  LFSR_SEED = 8'h01,
    parameter logic [RESP_WIDTH-1:0] MISR_TAPS = 8'hB8,
    parameter logic [RESP_WIDTH-1:0] MISR_SEED = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  learn,
    input  logic                  use_ext_golden,
    input  logic [RESP_WIDTH-1:0] golden_in,
    output logic [PAT_WIDTH-1:0]  pat_out,
    output logic                  pat_valid,
    input  logic [RESP_WIDTH-1:0] resp_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  golden_valid,
    output logic [RESP_WIDTH-1:0] signature
);

    localparam logic [PAT_WIDTH-1:0] SEED =
        (LFSR_SEED == '0) ? PAT_WIDTH'(1) : LFSR_SEED;
    localparam int CW = $clog2(NUM_PATTERNS + 8);
    localparam logic [CW-1:0] LAST_PAT = CW'(NUM_PATTERNS - 1);
    localparam logic [CW-1:0] LAST_DRAIN =
        CW'((CUT_LATENCY == 0) ? 0 : CUT_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE, INIT, RUN, DRAIN, COMPARE, DONE
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic                  learn_q;
    logic                  ext_q;
    logic [RESP_WIDTH-1:0] golden;
    logic                  resp_valid;
    logic [PAT_WIDTH-1:0]  lfsr_next;
    logic [RESP_WIDTH-1:0] misr_next;

    assign lfsr_next = {pat_out[PAT_WIDTH-2:0], ^(pat_out & LFSR_TAPS)};
    assign misr_next = {signature[RESP_WIDTH-2:0], ^(signature & MISR_TAPS)}
                       ^ resp_in;

    // pat_valid delayed to line up with the CUT's registered responses
    generate
        if (CUT_LATENCY == 0) begin : g_nolat
            assign resp_valid = pat_valid;
        end else begin : g_lat
            logic [CUT_LATENCY-1:0] vpipe;
            always_ff @(posedge clk) begin
                if (rst) begin
                    vpipe <= '0;
                end else begin
                    vpipe    <= vpipe << 1;
                    vpipe[0] <= pat_valid;
                end
            end
            assign resp_valid = vpipe[CUT_LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            learn_q      <= 1'b0;
            ext_q        <= 1'b0;
            golden       <= '0;
            golden_valid <= 1'b0;
            pat_out      <= SEED;
            pat_valid    <= 1'b0;
            signature    <= MISR_SEED;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            if (resp_valid) begin
                signature <= misr_next;
            end
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= INIT;
                        learn_q <= learn;
                        ext_q   <= use_ext_golden;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                    end
                end
                INIT: begin
                    pat_out   <= SEED;
                    signature <= MISR_SEED;
                    cnt       <= '0;
                    pat_valid <= 1'b1;
                    state     <= RUN;
                end
                RUN: begin
                    pat_out <= lfsr_next;
                    if (cnt == LAST_PAT) begin
                        cnt       <= '0;
                        pat_valid <= 1'b0;
                        state     <= (CUT_LATENCY == 0) ? COMPARE : DRAIN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (cnt == LAST_DRAIN) begin
                        state <= COMPARE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                COMPARE: begin
                    if (learn_q) begin
                        golden       <= signature;
                        golden_valid <= 1'b1;
                        pass         <= 1'b1;
                    end else if (ext_q) begin
                        pass <= (signature == golden_in);
                    end else begin
                        pass <= golden_valid && (signature == golden);
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_engine_param.sv
// Randomised self-checking bench for bist_engine_param driving a registered
// 4x4 multiplier CUT; expected signatures come from a pattern-list model.
module tb_bist_engine_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       learn = 1'b0;
    logic       use_ext_golden = 1'b0;
    logic [7:0] golden_in = 8'h00;
    logic [7:0] pat_out;
    logic       pat_valid;
    logic [7:0] resp_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic       golden_valid;
    logic [7:0] signature;

    logic [7:0] prod = 8'h00;
    logic [7:0] orm = 8'h00;
    logic [7:0] xm = 8'h00;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] pats [16];
    logic [7:0] gold_m = 8'h00;
    bit         gv_m = 1'b0;
    logic [7:0] learned;

    always #5 clk = ~clk;

    bist_engine_param #(
        .PAT_WIDTH(8),
        .RESP_WIDTH(8),
        .NUM_PATTERNS(15),
        .CUT_LATENCY(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .learn(learn),
        .use_ext_golden(use_ext_golden),
        .golden_in(golden_in),
        .pat_out(pat_out),
        .pat_valid(pat_valid),
        .resp_in(resp_in),
        .busy(busy),
        .done(done),
        .pass(pass),
        .golden_valid(golden_valid),
        .signature(signature)
    );

    // registered CUT with injectable stuck-at-one / bit-flip faults
    always_ff @(posedge clk) prod <= 8'(pat_out[7:4]) * 8'(pat_out[3:0]);
    assign resp_in = (prod | orm) ^ xm;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] model_sig(input logic [7:0] o,
                                             input logic [7:0] x);
        logic [7:0] m;
        logic [7:0] r;
        m = 8'h00;
        for (int i = 0; i < 15; i++) begin
            r = ((8'(pats[i][7:4]) * 8'(pats[i][3:0])) | o) ^ x;
            m = {m[6:0], ^(m & 8'hB8)} ^ r;
        end
        return m;
    endfunction

    task automatic run(input bit lrn, input bit ext, input logic [7:0] gin,
                       input logic [7:0] o, input logic [7:0] x,
                       input int pulse, input bit hold, input bit relaunch);
        int         lat;
        int         bad_busy;
        logic [7:0] es;
        bit         ep;
        if (!relaunch) @(negedge clk);
        learn = lrn;
        use_ext_golden = ext;
        golden_in = gin;
        orm = o;
        xm = x;
        start = 1'b1;
        @(posedge clk);
        lat = 0;
        bad_busy = 0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (j == 1 && !hold) start = 1'b0;
            if (j == pulse) start = 1'b1;
            if (j == pulse + 1 && !hold) start = 1'b0;
            if (j >= 2 && j <= 6) begin
                chk("pat_out", pat_out, pats[j-2]);
                chk("pat_valid", pat_valid, 1);
            end
            if (done) begin
                lat = j;
                break;
            end
            if (!busy) bad_busy++;
        end
        es = model_sig(o, x);
        if (lrn) begin
            gold_m = es;
            gv_m = 1'b1;
            ep = 1'b1;
        end else if (ext) begin
            ep = (es == gin);
        end else begin
            ep = gv_m && (es == gold_m);
        end
        chk("done_latency", lat, 19);
        chk("busy_window", bad_busy, 0);
        chk("signature", signature, es);
        chk("pass", pass, ep);
        chk("golden_valid", golden_valid, gv_m);
        chk("done_busy", busy, 0);
        chk("done_pat_valid", pat_valid, 0);
        chk("done_pat_out", pat_out, pats[15]);
    endtask

    initial begin
        bit         lrn;
        bit         ext;
        logic [7:0] x;
        logic [7:0] gin;
        pats[0] = 8'h01;
        for (int i = 1; i < 16; i++)
            pats[i] = {pats[i-1][6:0], ^(pats[i-1] & 8'hB8)};

        repeat (3) @(negedge clk);
        chk("rst_pat_out", pat_out, 8'h01);
        chk("rst_signature", signature, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_golden_valid", golden_valid, 0);
        chk("rst_pat_valid", pat_valid, 0);
        rst = 1'b0;

        run(1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        learned = model_sig(8'h00, 8'h00);
        run(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        run(0, 0, 8'h00, 8'h01, 8'h00, 0, 0, 0);
        chk("fault_pass", pass, 0);
        run(0, 1, learned, 8'h00, 8'h00, 0, 0, 0);
        run(0, 1, learned ^ 8'h01, 8'h00, 8'h00, 0, 0, 0);
        run(0, 0, 8'h00, 8'h00, 8'h00, 3, 0, 0);
        run(0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
        run(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1);

        @(negedge clk);
        start = 1'b1;
        learn = 1'b0;
        use_ext_golden = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_pat_valid", pat_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        gv_m = 1'b0;
        gold_m = 8'h00;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pat_valid", pat_valid, 0);
        chk("abort_golden_valid", golden_valid, 0);
        chk("abort_pat_out", pat_out, 8'h01);

        run(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        chk("no_golden_pass", pass, 0);

        for (int i = 0; i < 10; i++) begin
            lrn = ($urandom_range(0, 3) == 0);
            ext = 1'($urandom_range(0, 1));
            x = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
            gin = ($urandom_range(0, 1) == 1) ? model_sig(8'h00, x)
                                              : 8'($urandom);
            run(lrn, ext, gin, 8'h00, x, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
